// File: rtl/ddr_ui_adapter.sv
// ddr_ui_adapter
// Bridges the cache-side command/beat interface onto the MIG native UI.
// Commands, packed write words and returned read words are each buffered
// in a small FIFO. One issue FSM serialises UI transactions: a write sends
// its data word first, then the command. A read is issued only when the
// read-data FIFO is guaranteed to have room for its return word.
// All FIFO depths are assumed to be powers of two (pointers wrap naturally).
`timescale 1ns/1ps
module ddr_ui_adapter #(
    parameter int CMD_DEPTH   = 4,
    parameter int WDATA_DEPTH = 4,
    parameter int RDATA_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [26:0]  address_i,
    input  logic         write_i,
    input  logic         read_i,
    input  logic         push_i,
    input  logic [63:0]  write_data_i,
    input  logic [7:0]   write_mask_i,
    input  logic         pull_i,
    output logic [63:0]  read_data_o,
    output logic         read_valid_o,
    output logic         ready_o,
    output logic         idle_o,
    output logic         error_o,
    input  logic         init_calib_complete_i,
    output logic [26:0]  app_addr_o,
    output logic [2:0]   app_cmd_o,
    output logic         app_en_o,
    input  logic         app_rdy_i,
    output logic [127:0] app_wdf_data_o,
    output logic [15:0]  app_wdf_mask_o,
    output logic         app_wdf_wren_o,
    output logic         app_wdf_end_o,
    input  logic         app_wdf_rdy_i,
    input  logic [127:0] app_rd_data_i,
    input  logic         app_rd_data_valid_i,
    input  logic         app_rd_data_end_i
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int WAW = $clog2(WDATA_DEPTH);
    localparam int WCW = WAW + 1;
    localparam int RAW = $clog2(RDATA_DEPTH);
    localparam int RCW = RAW + 1;
    localparam int SUMW = RCW + 1;

    localparam logic [2:0] UI_CMD_WRITE = 3'b000;
    localparam logic [2:0] UI_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WCMD  = 2'd2,
        ST_RCMD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {is_write, burst-aligned address}
    // ------------------------------------------------------------------
    logic [27:0]    cmd_mem_r [CMD_DEPTH];
    logic [CAW-1:0] cmd_wptr_r;
    logic [CAW-1:0] cmd_rptr_r;
    logic [CCW-1:0] cmd_cnt_r;
    logic           cmd_full_s;
    logic           cmd_empty_s;
    logic           cmd_req_s;
    logic           cmd_push_s;
    logic           cmd_pop_s;
    logic           cmd_drop_s;
    logic           cmd_both_s;
    logic [27:0]    cmd_wdata_s;
    logic [27:0]    cmd_head_s;

    // ------------------------------------------------------------------
    // Write packer and write-data FIFO: entry = {byte_en[15:0], data[127:0]}
    // ------------------------------------------------------------------
    logic           pk_valid_r;
    logic [63:0]    pk_data_r;
    logic [7:0]     pk_be_r;
    logic           pk_load_s;
    logic [143:0]   wd_entry_s;
    logic [143:0]   wd_mem_r [WDATA_DEPTH];
    logic [WAW-1:0] wd_wptr_r;
    logic [WAW-1:0] wd_rptr_r;
    logic [WCW-1:0] wd_cnt_r;
    logic           wd_full_s;
    logic           wd_empty_s;
    logic           wd_push_s;
    logic           wd_pop_s;
    logic           wd_drop_s;
    logic [143:0]   wd_head_s;

    // ------------------------------------------------------------------
    // Read-data FIFO, unpack pointer and outstanding-read counter
    // ------------------------------------------------------------------
    logic [127:0]   rd_mem_r [RDATA_DEPTH];
    logic [RAW-1:0] rd_wptr_r;
    logic [RAW-1:0] rd_rptr_r;
    logic [RCW-1:0] rd_cnt_r;
    logic           rd_full_s;
    logic           rd_empty_s;
    logic           rd_req_s;
    logic           rd_push_s;
    logic           rd_pop_s;
    logic           rd_drop_s;
    logic           rd_pull_s;
    logic [127:0]   rd_head_s;
    logic           half_r;
    logic [RCW-1:0] out_cnt_r;
    logic           out_inc_s;
    logic           out_dec_s;
    logic           out_uflow_s;
    logic           credit_ok_s;

    // ------------------------------------------------------------------
    // Issue FSM state and registered UI outputs
    // ------------------------------------------------------------------
    state_t         state_r;
    state_t         state_nxt_s;
    logic           app_en_r,       app_en_nxt_s;
    logic [2:0]     app_cmd_r,      app_cmd_nxt_s;
    logic [26:0]    app_addr_r,     app_addr_nxt_s;
    logic           app_wren_r,     app_wren_nxt_s;
    logic           app_wend_r,     app_wend_nxt_s;
    logic [127:0]   app_wdata_r,    app_wdata_nxt_s;
    logic [15:0]    app_wmask_r,    app_wmask_nxt_s;
    logic           error_r;

    // FIFO status decodes and head entries
    always_comb begin
        cmd_full_s  = (cmd_cnt_r == CCW'(CMD_DEPTH));
        cmd_empty_s = (cmd_cnt_r == CCW'(0));
        cmd_head_s  = cmd_mem_r[cmd_rptr_r];
        wd_full_s   = (wd_cnt_r == WCW'(WDATA_DEPTH));
        wd_empty_s  = (wd_cnt_r == WCW'(0));
        wd_head_s   = wd_mem_r[wd_rptr_r];
        rd_full_s   = (rd_cnt_r == RCW'(RDATA_DEPTH));
        rd_empty_s  = (rd_cnt_r == RCW'(0));
        rd_head_s   = rd_mem_r[rd_rptr_r];
        credit_ok_s = (({1'b0, out_cnt_r} + {1'b0, rd_cnt_r}) < SUMW'(RDATA_DEPTH));
    end

    // Command capture: a simultaneous write/read keeps the write and flags an error
    always_comb begin
        cmd_req_s   = write_i | read_i;
        cmd_both_s  = write_i & read_i;
        cmd_wdata_s = {write_i, address_i[26:3], 3'b000};
        cmd_push_s  = cmd_req_s & ~(cmd_full_s & ~cmd_pop_s);
        cmd_drop_s  = cmd_req_s & cmd_full_s & ~cmd_pop_s;
    end

    // Command FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cmd_mem_r[i] <= 28'h0;
            end
            cmd_wptr_r <= CAW'(0);
            cmd_rptr_r <= CAW'(0);
            cmd_cnt_r  <= CCW'(0);
        end else begin
            if (cmd_push_s) begin
                cmd_mem_r[cmd_wptr_r] <= cmd_wdata_s;
                cmd_wptr_r            <= cmd_wptr_r + CAW'(1);
            end
            if (cmd_pop_s) begin
                cmd_rptr_r <= cmd_rptr_r + CAW'(1);
            end
            case ({cmd_push_s, cmd_pop_s})
                2'b10:   cmd_cnt_r <= cmd_cnt_r + CCW'(1);
                2'b01:   cmd_cnt_r <= cmd_cnt_r - CCW'(1);
                default: cmd_cnt_r <= cmd_cnt_r;
            endcase
        end
    end

    // Packer commit: a held low beat always commits on the following cycle,
    // merged with a new beat if one arrives, otherwise with the high half disabled
    always_comb begin
        pk_load_s = push_i & ~pk_valid_r;
        if (push_i) begin
            wd_entry_s = {write_mask_i, pk_be_r, write_data_i, pk_data_r};
        end else begin
            wd_entry_s = {8'h00, pk_be_r, 64'h0, pk_data_r};
        end
        wd_push_s = pk_valid_r & ~(wd_full_s & ~wd_pop_s);
        wd_drop_s = pk_valid_r & wd_full_s & ~wd_pop_s;
    end

    // Packer low-half holding register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pk_valid_r <= 1'b0;
            pk_data_r  <= 64'h0;
            pk_be_r    <= 8'h00;
        end else if (pk_load_s) begin
            pk_valid_r <= 1'b1;
            pk_data_r  <= write_data_i;
            pk_be_r    <= write_mask_i;
        end else begin
            pk_valid_r <= 1'b0;
        end
    end

    // Write-data FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < WDATA_DEPTH; i++) begin
                wd_mem_r[i] <= 144'h0;
            end
            wd_wptr_r <= WAW'(0);
            wd_rptr_r <= WAW'(0);
            wd_cnt_r  <= WCW'(0);
        end else begin
            if (wd_push_s) begin
                wd_mem_r[wd_wptr_r] <= wd_entry_s;
                wd_wptr_r           <= wd_wptr_r + WAW'(1);
            end
            if (wd_pop_s) begin
                wd_rptr_r <= wd_rptr_r + WAW'(1);
            end
            case ({wd_push_s, wd_pop_s})
                2'b10:   wd_cnt_r <= wd_cnt_r + WCW'(1);
                2'b01:   wd_cnt_r <= wd_cnt_r - WCW'(1);
                default: wd_cnt_r <= wd_cnt_r;
            endcase
        end
    end

    // Issue FSM next state; UI outputs only change on transitions
    always_comb begin
        state_nxt_s     = state_r;
        app_en_nxt_s    = app_en_r;
        app_cmd_nxt_s   = app_cmd_r;
        app_addr_nxt_s  = app_addr_r;
        app_wren_nxt_s  = app_wren_r;
        app_wend_nxt_s  = app_wend_r;
        app_wdata_nxt_s = app_wdata_r;
        app_wmask_nxt_s = app_wmask_r;
        wd_pop_s        = 1'b0;
        cmd_pop_s       = 1'b0;
        out_inc_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (init_calib_complete_i && !cmd_empty_s && cmd_head_s[27] && !wd_empty_s) begin
                    state_nxt_s     = ST_WDATA;
                    app_wren_nxt_s  = 1'b1;
                    app_wend_nxt_s  = 1'b1;
                    app_wdata_nxt_s = wd_head_s[127:0];
                    app_wmask_nxt_s = ~wd_head_s[143:128];
                    app_addr_nxt_s  = cmd_head_s[26:0];
                end else if (init_calib_complete_i && !cmd_empty_s && !cmd_head_s[27] && credit_ok_s) begin
                    state_nxt_s    = ST_RCMD;
                    app_en_nxt_s   = 1'b1;
                    app_cmd_nxt_s  = UI_CMD_READ;
                    app_addr_nxt_s = cmd_head_s[26:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (app_wdf_rdy_i) begin
                    wd_pop_s       = 1'b1;
                    state_nxt_s    = ST_WCMD;
                    app_wren_nxt_s = 1'b0;
                    app_wend_nxt_s = 1'b0;
                    app_en_nxt_s   = 1'b1;
                    app_cmd_nxt_s  = UI_CMD_WRITE;
                end else begin
                    state_nxt_s = ST_WDATA;
                end
            end
            ST_WCMD: begin
                if (app_rdy_i) begin
                    cmd_pop_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    app_en_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_WCMD;
                end
            end
            ST_RCMD: begin
                if (app_rdy_i) begin
                    cmd_pop_s    = 1'b1;
                    out_inc_s    = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    app_en_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RCMD;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                app_en_nxt_s   = 1'b0;
                app_wren_nxt_s = 1'b0;
                app_wend_nxt_s = 1'b0;
            end
        endcase
    end

    // Issue FSM state and UI output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            app_en_r    <= 1'b0;
            app_cmd_r   <= 3'b000;
            app_addr_r  <= 27'h0;
            app_wren_r  <= 1'b0;
            app_wend_r  <= 1'b0;
            app_wdata_r <= 128'h0;
            app_wmask_r <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            app_en_r    <= app_en_nxt_s;
            app_cmd_r   <= app_cmd_nxt_s;
            app_addr_r  <= app_addr_nxt_s;
            app_wren_r  <= app_wren_nxt_s;
            app_wend_r  <= app_wend_nxt_s;
            app_wdata_r <= app_wdata_nxt_s;
            app_wmask_r <= app_wmask_nxt_s;
        end
    end

    // Read return and unpack control; a return with nothing outstanding is a protocol error
    always_comb begin
        rd_req_s    = app_rd_data_valid_i & app_rd_data_end_i;
        rd_pull_s   = pull_i & ~rd_empty_s;
        rd_pop_s    = rd_pull_s & half_r;
        rd_push_s   = rd_req_s & ~(rd_full_s & ~rd_pop_s);
        rd_drop_s   = rd_req_s & rd_full_s & ~rd_pop_s;
        out_dec_s   = rd_req_s & (out_cnt_r != RCW'(0));
        out_uflow_s = rd_req_s & (out_cnt_r == RCW'(0));
    end

    // Read-data FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RDATA_DEPTH; i++) begin
                rd_mem_r[i] <= 128'h0;
            end
            rd_wptr_r <= RAW'(0);
            rd_rptr_r <= RAW'(0);
            rd_cnt_r  <= RCW'(0);
        end else begin
            if (rd_push_s) begin
                rd_mem_r[rd_wptr_r] <= app_rd_data_i;
                rd_wptr_r           <= rd_wptr_r + RAW'(1);
            end
            if (rd_pop_s) begin
                rd_rptr_r <= rd_rptr_r + RAW'(1);
            end
            case ({rd_push_s, rd_pop_s})
                2'b10:   rd_cnt_r <= rd_cnt_r + RCW'(1);
                2'b01:   rd_cnt_r <= rd_cnt_r - RCW'(1);
                default: rd_cnt_r <= rd_cnt_r;
            endcase
        end
    end

    // Half pointer: low half first, popping the entry after the high half
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            half_r <= 1'b0;
        end else if (rd_pull_s) begin
            half_r <= ~half_r;
        end else begin
            half_r <= half_r;
        end
    end

    // Outstanding read counter; simultaneous issue and return cancel out
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_cnt_r <= RCW'(0);
        end else begin
            case ({out_inc_s, out_dec_s})
                2'b10:   out_cnt_r <= out_cnt_r + RCW'(1);
                2'b01:   out_cnt_r <= out_cnt_r - RCW'(1);
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

    // Sticky error flag collecting every dropped strobe or word
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r | cmd_drop_s | cmd_both_s | wd_drop_s | rd_drop_s | out_uflow_s;
        end
    end

    assign app_en_o       = app_en_r;
    assign app_cmd_o      = app_cmd_r;
    assign app_addr_o     = app_addr_r;
    assign app_wdf_wren_o = app_wren_r;
    assign app_wdf_end_o  = app_wend_r;
    assign app_wdf_data_o = app_wdata_r;
    assign app_wdf_mask_o = app_wmask_r;
    assign error_o        = error_r;
    assign read_valid_o   = ~rd_empty_s;
    assign read_data_o    = half_r ? rd_head_s[127:64] : rd_head_s[63:0];
    assign ready_o        = init_calib_complete_i & ~cmd_full_s & ~wd_full_s & ~pk_valid_r;
    assign idle_o         = (state_r == ST_IDLE) & cmd_empty_s & wd_empty_s & rd_empty_s
                            & ~pk_valid_r & (out_cnt_r == RCW'(0));

endmodule
